jogo_memoria_param: RTL and testbench

Parametrised memory-game core: replays a stored sequence of one-hot button codes on the LEDs, growing by one element per round, and checks the player's presses against it. Generalises the fixed 4-button, ROM-based game to N buttons, configurable depth, a loadable sequence RAM, a run-time target length, and full-sequence playback before every round. Sits between the panel I/O (buttons, LEDs, 7-segment debug decoders) and the top-level game wrapper.

---
 rtl/jogo_memoria_param.sv | 213 +++++++++++++++++++++
 tb/tb_jogo_memoria_param.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jogo_memoria_param.sv
// Parametrised memory-game core: plays back a stored sequence of one-hot button
// codes on the LEDs, one element longer each round, and checks the player's
// presses against it. Sequence RAM is loadable while no game is running.
module jogo_memoria_param #(
    parameter int N_BOTOES = 4,
    parameter int PROF     = 16,
    parameter int TIMEOUT  = 5000,
    parameter int T_LED    = 500,
    parameter int T_PAUSA  = 250,
    localparam int AW      = $clog2(PROF)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic [AW-1:0]       alvo,
    input  logic                carga_we,
    input  logic [AW-1:0]       carga_end,
    input  logic [N_BOTOES-1:0] carga_dado,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                timeout,
    output logic [3:0]          db_estado,
    output logic [AW-1:0]       db_rodada
);

    // One shared cycle counter serves playback, pause and press-timeout timing,
    // so it is sized for the largest of the three intervals.
    localparam int CMAX_LP = (T_LED > T_PAUSA) ? T_LED : T_PAUSA;
    localparam int CMAX    = (TIMEOUT > CMAX_LP) ? TIMEOUT : CMAX_LP;
    localparam int CW      = $clog2(CMAX + 1);

    localparam logic [CW-1:0] LED_FIM    = CW'(T_LED - 1);
    localparam logic [CW-1:0] PAUSA_FIM  = CW'(T_PAUSA - 1);
    localparam logic [CW-1:0] ESPERA_FIM = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        MOSTRA      = 4'd2,
        PAUSA       = 4'd3,
        ESPERA      = 4'd4,
        REGISTRA    = 4'd5,
        COMPARA     = 4'd6,
        SOLTA       = 4'd7,
        PROX        = 4'd8,
        FIM_GANHOU  = 4'd9,
        FIM_PERDEU  = 4'd10,
        FIM_TIMEOUT = 4'd11
    } estado_t;

    estado_t             estado, estado_n;
    logic [AW-1:0]       rodada, rodada_n;
    logic [AW-1:0]       k, k_n;
    logic [AW-1:0]       j, j_n;
    logic [AW-1:0]       alvo_r, alvo_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [N_BOTOES-1:0] captura;
    logic [N_BOTOES-1:0] mem [PROF];
    logic                carga_ok;

    // The RAM may only change between games, never under a running sequence.
    assign carga_ok = (estado == INICIAL) || (estado == FIM_GANHOU) ||
                      (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);

    // Sequence RAM and press capture; neither is reset so RAM survives reset.
    always_ff @(posedge clock) begin
        if (carga_we && carga_ok) begin
            mem[carga_end] <= carga_dado;
        end
        if (estado == REGISTRA) begin
            captura <= botoes;
        end
    end

    // State register plus round, playback, entry and timer counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
            rodada <= '0;
            k      <= '0;
            j      <= '0;
            alvo_r <= '0;
            cnt    <= '0;
        end else begin
            estado <= estado_n;
            rodada <= rodada_n;
            k      <= k_n;
            j      <= j_n;
            alvo_r <= alvo_n;
            cnt    <= cnt_n;
        end
    end

    // Next-state, counter updates and Moore outputs.
    always_comb begin
        estado_n = estado;
        rodada_n = rodada;
        k_n      = k;
        j_n      = j;
        alvo_n   = alvo_r;
        cnt_n    = cnt;
        leds     = '0;
        pronto   = 1'b0;
        ganhou   = 1'b0;
        perdeu   = 1'b0;
        timeout  = 1'b0;

        case (estado)
            INICIAL: begin
                if (jogar) estado_n = PREPARA;
            end
            PREPARA: begin
                rodada_n = '0;
                k_n      = '0;
                j_n      = '0;
                alvo_n   = alvo;
                cnt_n    = '0;
                estado_n = MOSTRA;
            end
            MOSTRA: begin
                leds = mem[k];
                if (cnt == LED_FIM) begin
                    cnt_n    = '0;
                    estado_n = PAUSA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PAUSA: begin
                if (cnt == PAUSA_FIM) begin
                    cnt_n = '0;
                    if (k < rodada) begin
                        k_n      = k + AW'(1);
                        estado_n = MOSTRA;
                    end else begin
                        k_n      = '0;
                        estado_n = ESPERA;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ESPERA: begin
                leds = botoes;
                // A press on the last allowed cycle still wins over the timeout.
                if (botoes != '0) begin
                    estado_n = REGISTRA;
                end else if (cnt == ESPERA_FIM) begin
                    estado_n = FIM_TIMEOUT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            REGISTRA: begin
                leds     = botoes;
                estado_n = COMPARA;
            end
            COMPARA: begin
                leds = botoes;
                // Exact match required: an extra button held counts as wrong.
                if (captura != mem[j]) estado_n = FIM_PERDEU;
                else                   estado_n = SOLTA;
            end
            SOLTA: begin
                leds = botoes;
                if (botoes == '0) begin
                    if (j < rodada) begin
                        j_n      = j + AW'(1);
                        cnt_n    = '0;
                        estado_n = ESPERA;
                    end else if (rodada == alvo_r) begin
                        estado_n = FIM_GANHOU;
                    end else begin
                        estado_n = PROX;
                    end
                end
            end
            PROX: begin
                rodada_n = rodada + AW'(1);
                j_n      = '0;
                k_n      = '0;
                cnt_n    = '0;
                estado_n = MOSTRA;
            end
            FIM_GANHOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
                if (jogar) estado_n = PREPARA;
            end
            FIM_PERDEU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
                if (jogar) estado_n = PREPARA;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                perdeu  = 1'b1;
                timeout = 1'b1;
                if (jogar) estado_n = PREPARA;
            end
            default: begin
                estado_n = INICIAL;
            end
        endcase
    end

    assign db_estado = estado;
    assign db_rodada = rodada;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Bench for jogo_memoria_param: a reference model of the game (sequence array
// plus per-game plan) pushes expected playback elements and end-of-game
// outcomes into queues; a monitor pops and compares as the DUT presents them.
module tb_jogo_memoria_param;

    localparam int N    = 4;
    localparam int PROF = 16;
    localparam int AW   = 4;
    localparam int TO   = 20;
    localparam int TL   = 4;
    localparam int TP   = 2;

    localparam int MODE_OK   = 0;
    localparam int MODE_ERR  = 1;
    localparam int MODE_TO   = 2;
    localparam int MODE_LATE = 3;

    typedef struct packed {
        logic [3:0]    est;
        logic          g;
        logic          p;
        logic          t;
        logic [AW-1:0] rod;
    } fim_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          jogar;
    logic [AW-1:0] alvo;
    logic          carga_we;
    logic [AW-1:0] carga_end;
    logic [N-1:0]  carga_dado;
    logic [N-1:0]  botoes;
    logic [N-1:0]  leds;
    logic          pronto, ganhou, perdeu, timeout;
    logic [3:0]    db_estado;
    logic [AW-1:0] db_rodada;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] ref_mem [PROF];
    logic [N-1:0] exp_play [$];
    fim_t         exp_end [$];

    jogo_memoria_param #(
        .N_BOTOES(N), .PROF(PROF), .TIMEOUT(TO), .T_LED(TL), .T_PAUSA(TP)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .alvo(alvo),
        .carga_we(carga_we), .carga_end(carga_end), .carga_dado(carga_dado),
        .botoes(botoes), .leds(leds), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .timeout(timeout), .db_estado(db_estado),
        .db_rodada(db_rodada)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, got, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [3:0]   est_ant    = 4'd0;
    logic         pronto_ant = 1'b0;
    int           lit        = 0;
    int           dark       = 0;
    logic [N-1:0] cur_exp    = '0;
    fim_t         e_fim;

    always @(negedge clock) begin
        if (!reset) begin
            est_ant    = 4'd0;
            pronto_ant = 1'b0;
            lit        = 0;
            dark       = 0;
        end else begin
            if (db_estado == 4'd2) begin
                if (est_ant != 4'd2) begin
                    check("play_avail", exp_play.size() > 0, 1);
                    if (exp_play.size() > 0) cur_exp = exp_play.pop_front();
                    lit = 0;
                end
                lit++;
                check("leds_mostra", leds, cur_exp);
            end else if (est_ant == 4'd2) begin
                check("t_led", lit, TL);
            end
            if (db_estado == 4'd3) begin
                if (est_ant != 4'd3) dark = 0;
                dark++;
                check("leds_pausa", leds, 0);
            end else if (est_ant == 4'd3) begin
                check("t_pausa", dark, TP);
            end
            if (db_estado >= 4'd4 && db_estado <= 4'd7) begin
                check("leds_echo", leds, botoes);
            end
            if (pronto && !pronto_ant) begin
                check("end_avail", exp_end.size() > 0, 1);
                check("play_drained", exp_play.size(), 0);
                if (exp_end.size() > 0) begin
                    e_fim = exp_end.pop_front();
                    check("end_estado", db_estado, e_fim.est);
                    check("end_ganhou", ganhou, e_fim.g);
                    check("end_perdeu", perdeu, e_fim.p);
                    check("end_timeout", timeout, e_fim.t);
                    check("end_rodada", db_rodada, e_fim.rod);
                    check("end_leds", leds, 0);
                end
            end
            est_ant    = db_estado;
            pronto_ant = pronto;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_estado", db_estado, 0);
        check("rst_rodada", db_rodada, 0);
        check("rst_leds", leds, 0);
        check("rst_pronto", pronto, 0);
        check("rst_ganhou", ganhou, 0);
        check("rst_perdeu", perdeu, 0);
        check("rst_timeout", timeout, 0);
        exp_play.delete();
        exp_end.delete();
        botoes = '0;
        jogar  = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (db_estado == s) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check($sformatf("wait_state_%0d", s), db_estado, s);
    endtask

    task automatic wait_pronto(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (pronto) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) check("wait_pronto", pronto, 1);
    endtask

    task automatic write_mem(input logic [AW-1:0] a, input logic [N-1:0] d, input bit taken);
        carga_we   = 1'b1;
        carga_end  = a;
        carga_dado = d;
        @(negedge clock);
        carga_we = 1'b0;
        if (taken) ref_mem[a] = d;
    endtask

    task automatic press(input logic [N-1:0] v, input int h);
        botoes = v;
        repeat (h) @(negedge clock);
        botoes = '0;
    endtask

    // Plays one game from INICIAL or a FIM state according to a plan.
    task automatic run_game(input int av, input int mode, input int er, input int ei,
                            input logic [N-1:0] bad, input bit wr,
                            input logic [AW-1:0] wa, input logic [N-1:0] wd);
        int   last;
        bit   ok;
        fim_t f;
        if (wr) ref_mem[wa] = wd;
        last = (mode == MODE_ERR || mode == MODE_TO) ? er : av;
        for (int r = 0; r <= last; r++)
            for (int kk = 0; kk <= r; kk++)
                exp_play.push_back(ref_mem[kk]);
        f.rod = AW'(last);
        f.est = (mode == MODE_ERR) ? 4'd10 : (mode == MODE_TO) ? 4'd11 : 4'd9;
        f.g   = (mode == MODE_OK || mode == MODE_LATE);
        f.p   = (mode == MODE_ERR || mode == MODE_TO);
        f.t   = (mode == MODE_TO);
        exp_end.push_back(f);

        alvo  = AW'(av);
        jogar = 1'b1;
        if (wr) begin
            carga_we   = 1'b1;
            carga_end  = wa;
            carga_dado = wd;
        end
        @(negedge clock);
        jogar    = 1'b0;
        carga_we = 1'b0;
        check("start_prepara", db_estado, 1);
        @(negedge clock);
        check("start_mostra", db_estado, 2);
        check("start_leds", leds, ref_mem[0]);
        alvo = AW'($urandom);

        for (int r = 0; r <= last; r++) begin
            for (int jj = 0; jj <= r; jj++) begin
                wait_state(4'd4, 400, ok);
                if (!ok) begin
                    do_reset();
                    return;
                end
                if (r == er && jj == ei && mode == MODE_ERR) begin
                    botoes = bad;
                    @(negedge clock);
                    check("err_registra", db_estado, 5);
                    @(negedge clock);
                    check("err_compara", db_estado, 6);
                    check("err_perdeu_early", perdeu, 0);
                    botoes = '0;
                    @(negedge clock);
                    check("err_perdeu", perdeu, 1);
                    @(negedge clock);
                    return;
                end else if (r == er && jj == ei && mode == MODE_TO) begin
                    repeat (TO - 1) @(negedge clock);
                    check("to_last_espera", db_estado, 4);
                    check("to_not_yet", timeout, 0);
                    @(negedge clock);
                    check("to_estado", db_estado, 11);
                    check("to_flag", timeout, 1);
                    @(negedge clock);
                    return;
                end else if (r == er && jj == ei && mode == MODE_LATE) begin
                    repeat (TO - 1) @(negedge clock);
                    check("late_espera", db_estado, 4);
                    botoes = ref_mem[jj];
                    @(negedge clock);
                    check("late_registra", db_estado, 5);
                    @(negedge clock);
                    botoes = '0;
                end else begin
                    press(ref_mem[jj], 2 + int'($urandom_range(2)));
                end
            end
        end
        wait_pronto(40, ok);
        @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int av, md, er, ei;
        logic [N-1:0] bad;
        reset = 1'b1; jogar = 1'b0; alvo = '0; carga_we = 1'b0;
        carga_end = '0; carga_dado = '0; botoes = '0;

        do_reset();

        for (int a = 0; a < PROF; a++) begin
            if (a < 4) write_mem(AW'(a), N'(1 << a), 1'b1);
            else       write_mem(AW'(a), N'(1 << $urandom_range(N - 1)), 1'b1);
        end

        run_game(1, MODE_OK,   -1, -1, '0,       1'b0, '0, '0);
        run_game(3, MODE_ERR,   0,  0, 4'b0010,  1'b0, '0, '0);
        run_game(3, MODE_ERR,   1,  0, 4'b0011,  1'b0, '0, '0);
        run_game(3, MODE_TO,    1,  1, '0,       1'b0, '0, '0);
        run_game(2, MODE_LATE,  2,  1, '0,       1'b0, '0, '0);

        for (int g = 0; g < 6; g++) begin
            write_mem(AW'(4 + $urandom_range(PROF - 5)), N'(1 << $urandom_range(N - 1)), 1'b1);
            av  = int'($urandom_range(4));
            md  = int'($urandom_range(3));
            er  = int'($urandom_range(av));
            ei  = int'($urandom_range(er));
            bad = N'($urandom_range(15, 1));
            if (bad == ref_mem[ei]) bad = bad ^ 4'b0011;
            run_game(av, md, er, ei, bad, 1'b0, '0, '0);
        end

        // Write attempted during playback must not disturb the sequence.
        exp_play.push_back(ref_mem[0]);
        alvo  = AW'(2);
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
        wait_state(4'd2, 10, ok);
        write_mem('0, 4'b1000, 1'b0);
        check("write_ignored", leds, ref_mem[0]);
        wait_state(4'd4, 100, ok);
        do_reset();

        // Write and start in the same INICIAL cycle: new value is played.
        run_game(0, MODE_OK, -1, -1, '0, 1'b1, '0, 4'b0100);

        check("final_play_queue", exp_play.size(), 0);
        check("final_end_queue", exp_end.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
